// File: rtl/fmadd_rounding_pipe.sv
// fmadd_rounding_pipe
//
// Final rounding stage of the FMADD addition path, as a two-stage
// valid/ready pipeline. Takes the post-normalisation significand
// (hidden bit at MSB), the biased exponent with one bit of overflow
// headroom, the sign and the guard/round/sticky bits. It applies the
// five RISC-V rounding modes, saturates on overflow according to the
// mode, and raises OF/UF/NX. Also keeps a sticky accumulation of the
// flags of every result that leaves the block.
//
// Parameters
//   MAN : stored fraction width minus 1 (22 for FP32, 6 for bfloat16)
//   EXP : output exponent width minus 1 (7 for FP32 and bfloat16)
//
// Ports
//   clk, rst_l                 clock, asynchronous active-low reset
//   in_valid / in_ready        input handshake
//   in_mant [MAN+1:0]          significand, hidden bit at MSB
//   in_exp  [EXP+1:0]          biased exponent, unsigned
//   in_sign                    sign
//   in_guard/round/sticky      rounding bits below the LSB
//   in_frm  [2:0]              rounding mode
//   out_valid / out_ready      output handshake
//   out_sign, out_exp, out_mant  rounded result
//   out_flags [4:0]            {NV,DZ,OF,UF,NX} of this result
//   out_frm_err                in_frm was a reserved encoding
//   fflags_clr                 clear the accumulated flags
//   fflags_acc [4:0]           sticky OR of flags over output transfers
module fmadd_rounding_pipe #(
  parameter int MAN = 22,
  parameter int EXP = 7
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [MAN+1:0] in_mant,
  input  logic [EXP+1:0] in_exp,
  input  logic           in_sign,
  input  logic           in_guard,
  input  logic           in_round,
  input  logic           in_sticky,
  input  logic [2:0]     in_frm,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_sign,
  output logic [EXP:0]   out_exp,
  output logic [MAN:0]   out_mant,
  output logic [4:0]     out_flags,
  output logic           out_frm_err,
  input  logic           fflags_clr,
  output logic [4:0]     fflags_acc
);

  localparam logic [2:0] FRM_RNE = 3'b000;
  localparam logic [2:0] FRM_RTZ = 3'b001;
  localparam logic [2:0] FRM_RDN = 3'b010;
  localparam logic [2:0] FRM_RUP = 3'b011;
  localparam logic [2:0] FRM_RMM = 3'b100;

  localparam logic [EXP:0]   EXP_INF  = {(EXP+1){1'b1}};
  localparam logic [EXP:0]   EXP_MAXF = EXP_INF - 1'b1;
  localparam logic [MAN:0]   MAN_ONES = {(MAN+1){1'b1}};
  // Any exponent at or above the all-ones code is out of finite range.
  localparam logic [EXP+1:0] OVF_THRESH = {1'b0, EXP_INF};

  // ---------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------
  logic s1_valid;
  logic s2_advance;

  // The output register may take a new value when it is empty or being
  // drained this cycle; stage1 may take a new beat when it is empty or
  // moving into stage2. Neither term depends on in_valid.
  assign s2_advance = !out_valid | out_ready;
  assign in_ready   = !s1_valid | s2_advance;

  // ---------------------------------------------------------------
  // Stage1: round-up decision from the incoming bits
  // ---------------------------------------------------------------
  logic in_inx;
  logic in_rup;
  logic in_frm_err;

  assign in_inx = in_guard | in_round | in_sticky;

  always_comb begin
    in_rup     = 1'b0;
    in_frm_err = 1'b0;
    case (in_frm)
      // Above half, or exactly half with an odd LSB.
      FRM_RNE: in_rup = in_guard & (in_round | in_sticky | in_mant[0]);
      FRM_RTZ: in_rup = 1'b0;
      FRM_RDN: in_rup = in_inx & in_sign;
      FRM_RUP: in_rup = in_inx & !in_sign;
      // Ties away from zero: any guard bit means at least half.
      FRM_RMM: in_rup = in_guard;
      default: begin
        in_rup     = 1'b0;
        in_frm_err = 1'b1;
      end
    endcase
  end

  logic [MAN+1:0] s1_mant;
  logic [EXP+1:0] s1_exp;
  logic           s1_sign;
  logic           s1_inx;
  logic           s1_rup;
  logic [2:0]     s1_frm;
  logic           s1_frm_err;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid   <= 1'b0;
      s1_mant    <= '0;
      s1_exp     <= '0;
      s1_sign    <= 1'b0;
      s1_inx     <= 1'b0;
      s1_rup     <= 1'b0;
      s1_frm     <= 3'b000;
      s1_frm_err <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mant    <= in_mant;
        s1_exp     <= in_exp;
        s1_sign    <= in_sign;
        s1_inx     <= in_inx;
        s1_rup     <= in_rup;
        s1_frm     <= in_frm;
        s1_frm_err <= in_frm_err;
      end
    end
  end

  // ---------------------------------------------------------------
  // Stage2: increment, renormalise, overflow saturation, flags
  // ---------------------------------------------------------------
  logic [MAN+2:0] rnd_sum;
  logic           rnd_carry;
  logic [MAN+1:0] rnd_sig;
  logic [EXP+1:0] rnd_exp;
  logic           rnd_ovf;
  logic           rnd_normal;
  logic           sat_to_inf;

  assign rnd_sum   = {1'b0, s1_mant} + {{(MAN+2){1'b0}}, s1_rup};
  assign rnd_carry = rnd_sum[MAN+2];
  // A carry out means the significand wrapped to 1.000..0 one binade up.
  assign rnd_sig   = rnd_carry ? {1'b1, rnd_sum[MAN+1:1]} : rnd_sum[MAN+1:0];
  assign rnd_exp   = s1_exp + {{(EXP+1){1'b0}}, rnd_carry};
  assign rnd_ovf   = (rnd_exp >= OVF_THRESH);
  // Without the hidden bit the result is subnormal (or zero).
  assign rnd_normal = rnd_sig[MAN+1];

  // On overflow, modes that round towards the overflowing side go to
  // infinity; the others stop at the largest finite magnitude. Reserved
  // encodings are treated as round-towards-zero.
  always_comb begin
    sat_to_inf = 1'b0;
    case (s1_frm)
      FRM_RNE: sat_to_inf = 1'b1;
      FRM_RMM: sat_to_inf = 1'b1;
      FRM_RDN: sat_to_inf = s1_sign;
      FRM_RUP: sat_to_inf = !s1_sign;
      default: sat_to_inf = 1'b0;
    endcase
  end

  logic [EXP:0] res_exp;
  logic [MAN:0] res_mant;
  logic [4:0]   res_flags;

  always_comb begin
    res_exp   = '0;
    res_mant  = '0;
    res_flags = 5'b00000;
    if (rnd_ovf) begin
      res_exp  = sat_to_inf ? EXP_INF : EXP_MAXF;
      res_mant = sat_to_inf ? '0 : MAN_ONES;
    end else begin
      res_exp  = rnd_normal ? rnd_exp[EXP:0] : '0;
      res_mant = rnd_sig[MAN:0];
    end
    // {NV, DZ, OF, UF, NX}; invalid and divide-by-zero cannot arise here.
    res_flags[2] = rnd_ovf;
    res_flags[1] = !rnd_ovf & !rnd_normal & s1_inx;
    res_flags[0] = s1_inx | rnd_ovf;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      out_valid   <= 1'b0;
      out_sign    <= 1'b0;
      out_exp     <= '0;
      out_mant    <= '0;
      out_flags   <= 5'b00000;
      out_frm_err <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign    <= s1_sign;
        out_exp     <= res_exp;
        out_mant    <= res_mant;
        out_flags   <= res_flags;
        out_frm_err <= s1_frm_err;
      end
    end
  end

  // ---------------------------------------------------------------
  // Accumulated flags
  // ---------------------------------------------------------------
  logic out_fire;

  assign out_fire = out_valid & out_ready;

  // A clear coinciding with a transfer keeps that transfer's flags so
  // they are not lost.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fflags_acc <= 5'b00000;
    end else if (fflags_clr) begin
      fflags_acc <= out_fire ? out_flags : 5'b00000;
    end else if (out_fire) begin
      fflags_acc <= fflags_acc | out_flags;
    end
  end

endmodule

// File: tb/tb_fmadd_rounding_pipe.sv
module tb_fmadd_rounding_pipe;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  // FP32 instance (MAN=22, EXP=7)
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [23:0] a_in_mant = '0;
  logic [8:0]  a_in_exp = '0;
  logic        a_in_sign = 1'b0, a_in_guard = 1'b0, a_in_round = 1'b0, a_in_sticky = 1'b0;
  logic [2:0]  a_in_frm = '0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b1;
  logic        a_out_sign;
  logic [7:0]  a_out_exp;
  logic [22:0] a_out_mant;
  logic [4:0]  a_out_flags;
  logic        a_out_frm_err;
  logic        fflags_clr = 1'b0;
  logic [4:0]  a_fflags_acc;

  // bfloat16 instance (MAN=6, EXP=7)
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [7:0]  b_in_mant = '0;
  logic [8:0]  b_in_exp = '0;
  logic        b_in_sign = 1'b0, b_in_guard = 1'b0, b_in_round = 1'b0, b_in_sticky = 1'b0;
  logic [2:0]  b_in_frm = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic        b_out_sign;
  logic [7:0]  b_out_exp;
  logic [6:0]  b_out_mant;
  logic [4:0]  b_out_flags;
  logic        b_out_frm_err;
  logic [4:0]  b_fflags_acc;

  fmadd_rounding_pipe #(.MAN(22), .EXP(7)) dut_a (
    .clk(clk), .rst_l(rst_l),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_mant(a_in_mant), .in_exp(a_in_exp), .in_sign(a_in_sign),
    .in_guard(a_in_guard), .in_round(a_in_round), .in_sticky(a_in_sticky),
    .in_frm(a_in_frm),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sign(a_out_sign), .out_exp(a_out_exp), .out_mant(a_out_mant),
    .out_flags(a_out_flags), .out_frm_err(a_out_frm_err),
    .fflags_clr(fflags_clr), .fflags_acc(a_fflags_acc)
  );

  fmadd_rounding_pipe #(.MAN(6), .EXP(7)) dut_b (
    .clk(clk), .rst_l(rst_l),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_mant(b_in_mant), .in_exp(b_in_exp), .in_sign(b_in_sign),
    .in_guard(b_in_guard), .in_round(b_in_round), .in_sticky(b_in_sticky),
    .in_frm(b_in_frm),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sign(b_out_sign), .out_exp(b_out_exp), .out_mant(b_out_mant),
    .out_flags(b_out_flags), .out_frm_err(b_out_frm_err),
    .fflags_clr(1'b0), .fflags_acc(b_fflags_acc)
  );

  typedef struct {
    logic        sign;
    logic [63:0] exp;
    logic [63:0] mant;
    logic [4:0]  flags;
    logic        frm_err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  logic [4:0] acc_model = 5'd0;
  int nvec = 0;
  int ncmp = 0;
  int errs = 0;
  bit bp_mode = 1'b0;

  // Reference rounding: value of the bits below the LSB in eighths, then
  // decide the increment, renormalise, and saturate by mode.
  function automatic exp_t model(input longint unsigned mant, input longint unsigned ex,
                                 input bit sign, input bit g, input bit r, input bit s,
                                 input bit [2:0] frm, input int man, input int ew);
    exp_t o;
    int rb;
    bit inx, up, ovf, normal, to_inf;
    longint unsigned sig, e, maxe, one;
    one = 64'd1;
    rb = (g ? 4 : 0) + (r ? 2 : 0) + (s ? 1 : 0);
    inx = (rb != 0);
    o.frm_err = 1'b0;
    up = 1'b0;
    case (frm)
      3'd0: up = (rb > 4) || (rb == 4 && mant[0]);
      3'd1: up = 1'b0;
      3'd2: up = inx && sign;
      3'd3: up = inx && !sign;
      3'd4: up = (rb >= 4);
      default: begin up = 1'b0; o.frm_err = 1'b1; end
    endcase
    sig = mant + 64'(up);
    e = ex;
    if (sig >= (one << (man + 2))) begin
      sig = sig >> 1;
      e = (e + 1) % (one << (ew + 2));
    end
    maxe = (one << (ew + 1)) - 1;
    ovf = (e >= maxe);
    normal = (sig >= (one << (man + 1)));
    o.sign = sign;
    if (ovf) begin
      case (frm)
        3'd0, 3'd4: to_inf = 1'b1;
        3'd2: to_inf = sign;
        3'd3: to_inf = !sign;
        default: to_inf = 1'b0;
      endcase
      o.exp  = to_inf ? maxe : maxe - 1;
      o.mant = to_inf ? 64'd0 : (one << (man + 1)) - 1;
    end else begin
      o.exp  = normal ? e : 64'd0;
      o.mant = sig % (one << (man + 1));
    end
    o.flags = {2'b00, ovf, !ovf && !normal && inx, inx || ovf};
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    ncmp++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Drives one beat; the expected result is queued on the cycle the beat
  // is seen to be accepted. Returns just after the acceptance edge.
  task automatic send_a(input logic [23:0] m, input logic [8:0] x, input logic sg,
                        input logic g, input logic r, input logic s, input logic [2:0] f);
    bit ok;
    ok = 1'b0;
    a_in_mant = m; a_in_exp = x; a_in_sign = sg;
    a_in_guard = g; a_in_round = r; a_in_sticky = s; a_in_frm = f;
    a_in_valid = 1'b1;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (a_in_ready) begin
        qa.push_back(model(64'(m), 64'(x), sg, g, r, s, f, 22, 7));
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    nvec++;
    if (!ok) begin
      ncmp++; errs++;
      $display("FAIL send_a: beat not accepted within 300 cycles, mant %0h exp %0h", m, x);
    end
  endtask

  task automatic send_b(input logic [7:0] m, input logic [8:0] x, input logic sg,
                        input logic g, input logic r, input logic s, input logic [2:0] f);
    bit ok;
    ok = 1'b0;
    b_in_mant = m; b_in_exp = x; b_in_sign = sg;
    b_in_guard = g; b_in_round = r; b_in_sticky = s; b_in_frm = f;
    b_in_valid = 1'b1;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (b_in_ready) begin
        qb.push_back(model(64'(m), 64'(x), sg, g, r, s, f, 6, 7));
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    nvec++;
    if (!ok) begin
      ncmp++; errs++;
      $display("FAIL send_b: beat not accepted within 300 cycles, mant %0h exp %0h", m, x);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && (qa.size() != 0 || qb.size() != 0); k++) @(posedge clk);
    #1;
    chk("drain_qa_empty", 64'(qa.size()), 64'd0);
    chk("drain_qb_empty", 64'(qb.size()), 64'd0);
  endtask

  // Random backpressure and flag clears during the random phase.
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      fflags_clr  = ($urandom_range(0, 19) == 0);
    end
  end

  // Monitor for the FP32 instance, including the accumulated flags.
  always @(negedge clk) begin
    exp_t e;
    logic [4:0] xf;
    bit xfer;
    if (rst_l) begin
      chk("a_fflags_acc", 64'(a_fflags_acc), 64'(acc_model));
      xfer = a_out_valid && a_out_ready;
      xf = 5'd0;
      if (xfer) begin
        if (qa.size() == 0) begin
          ncmp++; errs++;
          $display("FAIL a_unexpected: output exp %0h mant %0h with nothing expected", a_out_exp, a_out_mant);
        end else begin
          e = qa.pop_front();
          $display("a out: sign %0d exp %0h mant %0h flags %05b frm_err %0d", a_out_sign, a_out_exp, a_out_mant, a_out_flags, a_out_frm_err);
          chk("a_sign", 64'(a_out_sign), 64'(e.sign));
          chk("a_exp", 64'(a_out_exp), e.exp);
          chk("a_mant", 64'(a_out_mant), e.mant);
          chk("a_flags", 64'(a_out_flags), 64'(e.flags));
          chk("a_frm_err", 64'(a_out_frm_err), 64'(e.frm_err));
          xf = e.flags;
        end
      end
      if (fflags_clr) acc_model = xfer ? xf : 5'd0;
      else if (xfer) acc_model = acc_model | xf;
    end
  end

  // Monitor for the bfloat16 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_l && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        ncmp++; errs++;
        $display("FAIL b_unexpected: output exp %0h mant %0h with nothing expected", b_out_exp, b_out_mant);
      end else begin
        e = qb.pop_front();
        $display("b out: sign %0d exp %0h mant %0h flags %05b frm_err %0d", b_out_sign, b_out_exp, b_out_mant, b_out_flags, b_out_frm_err);
        chk("b_sign", 64'(b_out_sign), 64'(e.sign));
        chk("b_exp", 64'(b_out_exp), e.exp);
        chk("b_mant", 64'(b_out_mant), e.mant);
        chk("b_flags", 64'(b_out_flags), 64'(e.flags));
        chk("b_frm_err", 64'(b_out_frm_err), 64'(e.frm_err));
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_fflags_acc", 64'(a_fflags_acc), 64'd0);
    chk("rst_out_exp", 64'(a_out_exp), 64'd0);
    chk("rst_out_mant", 64'(a_out_mant), 64'd0);
    chk("rst_out_flags", 64'(a_out_flags), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    rst_l = 1'b1;
    @(posedge clk); #1;

    // Round-carry, with latency: visible one edge after acceptance,
    // transferred on the second edge.
    send_a(24'hFFFFFF, 9'h07F, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    chk("lat_not_yet", 64'(a_out_valid), 64'd0);
    @(negedge clk);
    chk("lat_valid", 64'(a_out_valid), 64'd1);
    chk("lat_exp_80", 64'(a_out_exp), 64'h80);
    @(posedge clk); #1;

    // Directed corner cases
    send_a(24'hFFFFFF, 9'h0FE, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    send_a(24'h800000, 9'h100, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011);
    send_a(24'h800000, 9'h100, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
    send_a(24'h800000, 9'h100, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
    send_a(24'h000001, 9'h001, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100);
    send_a(24'h000001, 9'h001, 1'b0, 1'b1, 1'b0, 1'b0, 3'b101);
    send_a(24'h800002, 9'h050, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    send_a(24'h800003, 9'h050, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    send_a(24'h000000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    drain();

    // Backpressure: two beats fill the pipe, the third must wait.
    a_out_ready = 1'b0;
    send_a(24'h812345, 9'h090, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
    send_a(24'h9ABCDE, 9'h091, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010);
    @(negedge clk);
    chk("bp_in_ready_low", 64'(a_in_ready), 64'd0);
    @(posedge clk); #1;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 a_out_ready = 1'b1;
      end
      begin
        send_a(24'hFFFFFE, 9'h092, 1'b0, 1'b1, 1'b1, 1'b1, 3'b011);
        send_a(24'hC00001, 9'h0FE, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100);
        send_a(24'hA5A5A5, 9'h093, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
      end
    join
    drain();

    // Accumulated flags: clear alone, three inexact beats, clear + OF.
    @(posedge clk); #1 fflags_clr = 1'b1;
    @(posedge clk); #1 fflags_clr = 1'b0;
    @(negedge clk);
    chk("acc_clr_alone", 64'(a_fflags_acc), 64'd0);
    @(posedge clk); #1;
    send_a(24'h800001, 9'h080, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001);
    send_a(24'h900000, 9'h081, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001);
    send_a(24'hA00000, 9'h082, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001);
    drain();
    @(negedge clk);
    chk("acc_three_nx", 64'(a_fflags_acc), 64'h01);
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    send_a(24'hFFFFFF, 9'h0FE, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    for (int k = 0; k < 50 && !a_out_valid; k++) @(negedge clk);
    chk("of_beat_valid", 64'(a_out_valid), 64'd1);
    @(posedge clk); #1;
    fflags_clr = 1'b1;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    @(negedge clk);
    chk("acc_clr_with_of", 64'(a_fflags_acc), 64'h05);
    @(posedge clk); #1;

    // Reset while two beats are held in the pipe.
    a_out_ready = 1'b0;
    send_a(24'h8FFFFF, 9'h070, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
    send_a(24'hFFFFFF, 9'h0FE, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    #1 rst_l = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(a_out_valid), 64'd0);
    chk("midrst_fflags_acc", 64'(a_fflags_acc), 64'd0);
    qa.delete();
    acc_model = 5'd0;
    a_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_l = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(a_out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // bfloat16 directed
    send_b(8'hFF, 9'h0FE, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
    send_b(8'h80, 9'h07F, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    send_b(8'hFF, 9'h07F, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010);
    send_b(8'h01, 9'h001, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100);
    drain();

    // Random phase with random backpressure and clears.
    bp_mode = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [23:0] m;
          logic [8:0] x;
          m = 24'($urandom);
          if ($urandom_range(0, 3) != 0) m[23] = 1'b1;
          if ($urandom_range(0, 7) == 0) m = 24'hFFFFFF;
          x = ($urandom_range(0, 2) == 0) ? 9'($urandom_range(250, 260)) : 9'($urandom);
          if ($urandom_range(0, 31) == 0) x = 9'h1FF;
          send_a(m, x, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
        end
      end
      begin
        for (int i = 0; i < 120; i++) begin
          logic [7:0] m;
          logic [8:0] x;
          m = 8'($urandom);
          if ($urandom_range(0, 3) != 0) m[7] = 1'b1;
          if ($urandom_range(0, 5) == 0) m = 8'hFF;
          x = ($urandom_range(0, 2) == 0) ? 9'($urandom_range(250, 260)) : 9'($urandom);
          send_b(m, x, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
        end
      end
    join
    bp_mode = 1'b0;
    @(posedge clk); #2;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    fflags_clr = 1'b0;
    drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
